// File: rtl/mips_pkg.sv
// Shared datapath types: default word width and the skid-buffer state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package mips_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/mux_sel_pipe_skid_buf.sv
// Generic two-entry valid/ready register stage (main register M + skid register S), FIFO order.
// Latency: one cycle from accept to out_valid.
// Backpressure: in_ready is registered; one extra beat is absorbed after out_ready drops.
module skid_buf
    import mips_pkg::*;
#(
    parameter int PAY_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic [PAY_W-1:0] in_pay,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PAY_W-1:0] out_pay,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_t      state_q, state_d;
    logic [PAY_W-1:0] m_q, m_d;
    logic [PAY_W-1:0] s_q, s_d;
    logic             in_ready_q, in_ready_d;
    logic             acc;
    logic             lv;

    always_comb begin
        acc        = in_valid && in_ready_q;
        lv         = (state_q != EMPTY) && out_ready;
        state_d    = state_q;
        m_d        = m_q;
        s_d        = s_q;
        in_ready_d = 1'b0;

        case (state_q)
            EMPTY: begin
                if (acc) begin
                    m_d     = in_pay;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acc && !lv) begin
                    s_d     = in_pay;
                    state_d = FULL;
                end else if (acc) begin
                    m_d = in_pay;
                end else if (lv) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so the only event is the head leaving.
                if (lv) begin
                    m_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (flush) begin
            state_d = EMPTY;
        end

        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            m_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_pay   = m_q;

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N_IN:1 word selector; select resolved at accept, payload {word, sel, err} into a skid stage.
// Latency: one cycle from accept to out_valid.
// Backpressure: registered in_ready, two-entry skid absorbs one beat after out_ready drops.
module mux_sel_pipe
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int PAY_W = WIDTH + SEL_W + 1;

    logic [WIDTH-1:0] sel_word;
    logic             sel_err;
    logic [PAY_W-1:0] in_pay;
    logic [PAY_W-1:0] out_pay;

    // An out-of-range select matches no word, leaving the word at zero.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
        sel_err = (int'(in_sel) >= N_IN);
        in_pay  = {sel_word, in_sel, sel_err};
    end

    skid_buf #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_pay    (in_pay),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pay   (out_pay),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = out_pay[PAY_W-1 -: WIDTH];
    assign out_sel  = out_pay[SEL_W:1];
    assign out_err  = out_pay[0];

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: directed scenarios on 4x32 and 3x32 instances, randomized queue-model stress on 5x16.
module tb_mux_sel_pipe;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance a: N_IN=4, WIDTH=32
    logic         a_flush, a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
    logic [127:0] a_in_data;
    logic [1:0]   a_in_sel, a_out_sel;
    logic [31:0]  a_out_data;
    // Instance b: N_IN=3, WIDTH=32
    logic         b_flush, b_in_valid, b_in_ready, b_out_err, b_out_valid, b_out_ready;
    logic [95:0]  b_in_data;
    logic [1:0]   b_in_sel, b_out_sel;
    logic [31:0]  b_out_data;
    // Instance c: N_IN=5, WIDTH=16
    logic         c_flush, c_in_valid, c_in_ready, c_out_err, c_out_valid, c_out_ready;
    logic [79:0]  c_in_data;
    logic [2:0]   c_in_sel, c_out_sel;
    logic [15:0]  c_out_data;

    mux_sel_pipe #(.WIDTH(32), .N_IN(4)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .flush(a_flush), .in_data(a_in_data), .in_sel(a_in_sel),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data), .out_sel(a_out_sel),
        .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready));

    mux_sel_pipe #(.WIDTH(32), .N_IN(3)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .flush(b_flush), .in_data(b_in_data), .in_sel(b_in_sel),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data), .out_sel(b_out_sel),
        .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready));

    mux_sel_pipe #(.WIDTH(16), .N_IN(5)) u_dut_c (
        .clock(clock), .reset_n(reset_n), .flush(c_flush), .in_data(c_in_data), .in_sel(c_in_sel),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data), .out_sel(c_out_sel),
        .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(c_out_ready));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_flush = 0; a_in_valid = 0; a_in_sel = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_in_sel = 0; b_out_ready = 0; b_in_data = '0;
        c_flush = 0; c_in_valid = 0; c_in_sel = 0; c_out_ready = 0; c_in_data = '0;
        tick();
        tick();
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", a_in_ready); end
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
        n_tests++; if ({a_out_data, a_out_sel, a_out_err} !== 35'd0) begin n_fail++; $display("FAIL reset_out_payload got %h/%0d/%b want 0", a_out_data, a_out_sel, a_out_err); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL release_in_ready_before_edge got %b want 0", a_in_ready); end
        tick();
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready_after_edge got %b want 1", a_in_ready); end
    endtask

    task automatic test_stream();
        logic [31:0] words [4];
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        a_in_data   = {words[3], words[2], words[1], words[0]};
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_in_valid = 1'b1;
            a_in_sel   = 2'(i);
            tick();
            n_tests++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_hs[%0d] got rdy=%b vld=%b want 1/1", i, a_in_ready, a_out_valid); end
            n_tests++; if (a_out_data !== words[i] || a_out_sel !== 2'(i) || a_out_err !== 1'b0) begin n_fail++; $display("FAIL stream_data[%0d] got %h/%0d/%b want %h/%0d/0", i, a_out_data, a_out_sel, a_out_err, words[i], i); end
        end
        a_in_valid = 1'b0;
        tick();
        n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_drain got vld=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
    endtask

    task automatic test_backpressure();
        logic        t_iv  [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [1:0]  t_sel [7] = '{2, 3, 0, 0, 0, 0, 0};
        logic        t_ord [7] = '{1, 0, 0, 0, 1, 1, 1};
        logic        e_vld [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [31:0] e_dat [7] = '{32'h33333333, 32'h33333333, 32'h33333333, 32'h33333333,
                                   32'h44444444, 32'h11111111, 32'h0};
        logic        e_rdy [7] = '{1, 0, 0, 0, 1, 1, 1};
        a_in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        for (int i = 0; i < 7; i++) begin
            a_in_valid  = t_iv[i];
            a_in_sel    = t_sel[i];
            a_out_ready = t_ord[i];
            tick();
            n_tests++; if (a_out_valid !== e_vld[i] || a_in_ready !== e_rdy[i]) begin n_fail++; $display("FAIL bp_hs[%0d] got vld=%b rdy=%b want %b/%b", i, a_out_valid, a_in_ready, e_vld[i], e_rdy[i]); end
            if (e_vld[i]) begin
                n_tests++; if (a_out_data !== e_dat[i]) begin n_fail++; $display("FAIL bp_data[%0d] got %h want %h", i, a_out_data, e_dat[i]); end
            end
        end
    endtask

    task automatic test_out_of_range();
        b_in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_sel    = 2'd3;
        tick();
        n_tests++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h0 || b_out_err !== 1'b1 || b_out_sel !== 2'd3) begin n_fail++; $display("FAIL oor_sel3 got vld=%b %h err=%b sel=%0d want 1 0 err=1 sel=3", b_out_valid, b_out_data, b_out_err, b_out_sel); end
        b_in_sel = 2'd1;
        tick();
        n_tests++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h22222222 || b_out_err !== 1'b0 || b_out_sel !== 2'd1) begin n_fail++; $display("FAIL oor_sel1 got vld=%b %h err=%b sel=%0d want 1 22222222 err=0 sel=1", b_out_valid, b_out_data, b_out_err, b_out_sel); end
        b_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        a_in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd0;
        tick();
        a_in_sel = 2'd1;
        tick();
        n_tests++; if (a_in_ready !== 1'b0 || a_out_data !== 32'h11111111) begin n_fail++; $display("FAIL flush_fill got rdy=%b %h want 0 11111111", a_in_ready, a_out_data); end
        a_flush  = 1'b1;
        a_in_sel = 2'd2;
        tick();
        n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_full got vld=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
        // Flush while holding one beat and accepting another: both discarded.
        a_flush = 1'b0;
        a_in_sel = 2'd2;
        tick();
        a_flush  = 1'b1;
        a_in_sel = 2'd3;
        tick();
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_accept got vld=%b rdy=%b want 0/1", a_out_valid, a_in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost[%0d] got vld=%b want 0", i, a_out_valid); end
        end
    endtask

    task automatic test_async_reset();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd3;
        tick();
        tick();
        a_in_valid = 1'b0;
        n_tests++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_full got vld=%b rdy=%b want 1/0", a_out_valid, a_in_ready); end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_tests++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_out_data !== 32'h0) begin n_fail++; $display("FAIL areset_async got vld=%b rdy=%b %h want 0/0/0", a_out_valid, a_in_ready, a_out_data); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_release_early got %b want 0", a_in_ready); end
        tick();
        n_tests++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_release got rdy=%b vld=%b want 1/0", a_in_ready, a_out_valid); end
    endtask

    task automatic test_random_stress();
        logic [19:0] q[$];
        logic [19:0] exp_pay;
        logic [15:0] w;
        logic        acc, lv;
        int          beats = 0;
        int          cyc   = 0;
        q.delete();
        while (beats < 10000 && cyc < 40000) begin
            c_in_valid  = ($urandom_range(0, 9) < 8);
            c_in_sel    = 3'($urandom_range(0, 7));
            c_in_data   = {16'($urandom), $urandom, $urandom};
            c_out_ready = ($urandom_range(0, 9) < 7);
            c_flush     = ($urandom_range(0, 99) == 0);
            #1;
            // in_ready must reflect only buffered occupancy, never this cycle's out_ready.
            n_tests++; if (c_in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", cyc, c_in_ready, q.size() < 2); end
            n_tests++; if (c_out_valid !== (q.size() != 0)) begin n_fail++; $display("FAIL rnd_out_valid cyc %0d got %b want %b", cyc, c_out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                n_tests++; if ({c_out_data, c_out_sel, c_out_err} !== q[0]) begin n_fail++; $display("FAIL rnd_payload cyc %0d got %h want %h", cyc, {c_out_data, c_out_sel, c_out_err}, q[0]); end
            end
            acc = c_in_valid && (q.size() < 2);
            lv  = c_out_ready && (q.size() != 0);
            w   = (c_in_sel < 3'd5) ? c_in_data[c_in_sel*16 +: 16] : 16'h0;
            exp_pay = {w, c_in_sel, (c_in_sel >= 3'd5)};
            tick();
            cyc++;
            if (lv) begin
                void'(q.pop_front());
                beats++;
            end
            if (c_flush) q.delete();
            else if (acc) q.push_back(exp_pay);
        end
        c_in_valid = 1'b0;
        c_flush    = 1'b0;
        n_tests++; if (beats < 10000) begin n_fail++; $display("FAIL rnd_budget got %0d beats want 10000 within 40000 cycles", beats); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_out_of_range();
        test_flush();
        test_async_reset();
        test_random_stress();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised, registered N-input word selector with a valid/ready handshake and a two-entry skid buffer. It is the pipelined successor to the fixed 4×32 combinational selector. It sits at pipeline stage boundaries of the MIPS datapath, such as the ALU-operand or writeback-source select, where the selected word must be registered and stalls must propagate without bubbles or combinational ready paths.

## Interface
Parameters:
- `WIDTH`, 32: data word width in bits.
- `N_IN`, 4: number of input words, 2..16.
- `SEL_W`, `$clog2(N_IN)`: select width (derived; do not override).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous discard of all buffered beats.
- `in_data`  in  N_IN*WIDTH  flattened inputs; word k = `in_data[k*WIDTH +: WIDTH]`.
- `in_sel`  in  SEL_W  index of the word to forward.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  registered; the stage can accept a beat.
- `out_data`  out  WIDTH  selected word.
- `out_sel`  out  SEL_W  echo of the `in_sel` that produced `out_data`.
- `out_err`  out  1  beat had `in_sel >= N_IN`.
- `out_valid`  out  1  output beat present.
- `out_ready`  in  1  downstream accepts.

## Operation
- A beat is accepted when `in_valid && in_ready` on a rising edge. A beat leaves when `out_valid && out_ready`.
- The select is resolved at accept time. The stored payload is {word, sel, err}.
- Out-of-range select (`in_sel >= N_IN`, possible only when N_IN is not a power of two): stored word = 0, err = 1.
- Storage: main register M (drives the outputs) and skid register S. Beats leave in strict FIFO order.
- State machine:
  - EMPTY: accept goes to ONE.
  - ONE: accept with no leave goes to FULL (beat into S). Accept with leave stays in ONE (beat into M). Leave with no accept goes to EMPTY.
  - FULL: leave moves S into M and goes to ONE. No accept is possible in FULL.
- `in_ready` register next value = (next state != FULL). It therefore never depends combinationally on `out_ready`.
- `flush`: next state is EMPTY and both entries are invalidated. A beat handshaken in the flush cycle is discarded. A leave in the flush cycle still completes downstream. `in_ready` is 1 the cycle after the flush.
- Flush is ignored while `reset_n` is low.
- `out_valid`, `out_data`, `out_sel` and `out_err` stay stable while `out_valid && !out_ready`.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sel`=0, `out_err`=0, state EMPTY.
- `in_ready` rises on the first clock edge after `reset_n` deasserts.
- Latency: a beat accepted at edge t appears with `out_valid`=1 after edge t (one cycle).
- Throughput: one beat per cycle while `out_ready`=1.
- Absorbing a stall: after `out_ready` falls, exactly one further beat is absorbed (into S), then `in_ready`=0.
- Recovery: `in_ready` returns to 1 the cycle after the first leave from FULL.
- Reset mid-operation: all beats are lost and outputs return to reset values immediately (asynchronous).
- The output registers are the sole sequential path. Input-to-register logic is one N_IN:1 mux.

## Structure
- Shared package `mips_pkg`: state enum `skid_state_t` {EMPTY, ONE, FULL}. Data width constant `WORD_W = 32` as the default for `WIDTH`.
- One sub-module: `skid_buf`, a generic two-entry valid/ready register stage parametrised on payload width, here WIDTH+SEL_W+1.
- `mux_sel_pipe` contains only the select/err logic feeding `skid_buf`.

## Test plan
- Reset then stream: N_IN=4, words {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel 0,1,2,3 on consecutive cycles, `out_ready`=1 -> outputs 0x11111111..0x44444444 one per cycle starting one cycle after the first accept, `in_ready` held at 1.
- Backpressure: `out_ready`=0 for 3 cycles during a stream of sels 2,3,0 -> `out_data` holds 0x33333333, 0x44444444 is stored in S, `in_ready`=0 for the next cycle. After `out_ready`=1, outputs are 0x33333333, 0x44444444, 0x11111111 in order with nothing lost or duplicated.
- Out-of-range: N_IN=3, `in_sel`=3 -> `out_data`=0, `out_err`=1, `out_sel`=3. A following `in_sel`=1 beat -> `out_err`=0.
- Flush when FULL: fill both entries, assert `flush` with `in_valid`=1 -> the next cycle has `out_valid`=0 and `in_ready`=1, and the beat offered in the flush cycle never appears.
- Async reset mid-stream: drop `reset_n` between edges while FULL -> `out_valid` and `in_ready` go to 0 without a clock edge. After release, `in_ready`=1 one edge later.
- Random stress: N_IN=5, WIDTH=16, random `in_valid` and `out_ready`, 10k beats compared against a scoreboard queue. There must be no combinational path from `out_ready` to `in_ready` (verified by one-cycle-delayed `in_ready` response).
